// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks the EX/MEM/WB destinations and produces
// stall/bubble/flush/freeze controls, EX operand-forwarding selects and a stall counter.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_stall,
  output logic             stall_if,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             freeze_all,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  logic             ex_valid_q, ex_valid_d;
  logic [4:0]       ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic             ex_reg_write_q, ex_reg_write_d, ex_mem_read_q, ex_mem_read_d;
  logic             ex_uses_rs1_q, ex_uses_rs1_d, ex_uses_rs2_q, ex_uses_rs2_d;
  logic             mem_valid_q, mem_valid_d, mem_reg_write_q, mem_reg_write_d;
  logic             mem_mem_read_q, mem_mem_read_d;
  logic [4:0]       mem_rd_q, mem_rd_d;
  logic             wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  // Outputs stay quiet until the first edge after reset release.
  logic             out_en_q;
  logic             load_use;

  function automatic logic hit(input logic v, input logic rw,
                               input logic [4:0] rd, input logic [4:0] src);
    return v & rw & (rd != 5'd0) & (rd == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
      input logic ex_v, input logic mem_v, input logic mem_rw, input logic mem_ld,
      input logic [4:0] mem_rd, input logic wb_v, input logic wb_rw, input logic [4:0] wb_rd);
    if (!ex_v || !used)                          return FWD_RF;
    if (hit(mem_v, mem_rw, mem_rd, src) && !mem_ld) return FWD_MEM;
    if (hit(wb_v, wb_rw, wb_rd, src))            return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    stall_if    = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    freeze_all  = 1'b0;
    load_use = id_valid & ex_mem_read_q &
               ((id_uses_rs1 & hit(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs1)) |
                (id_uses_rs2 & hit(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs2)));
    if (out_en_q) begin
      if (mem_stall) begin
        freeze_all = 1'b1;
      end else if (ex_branch_taken) begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else if (load_use) begin
        stall_if    = 1'b1;
        bubble_idex = 1'b1;
      end
    end
    fwd_a_sel = fwd_sel(ex_uses_rs1_q, ex_rs1_q, ex_valid_q, mem_valid_q, mem_reg_write_q,
                        mem_mem_read_q, mem_rd_q, wb_valid_q, wb_reg_write_q, wb_rd_q);
    fwd_b_sel = fwd_sel(ex_uses_rs2_q, ex_rs2_q, ex_valid_q, mem_valid_q, mem_reg_write_q,
                        mem_mem_read_q, mem_rd_q, wb_valid_q, wb_reg_write_q, wb_rd_q);
  end

  always_comb begin
    ex_valid_d = ex_valid_q;  ex_rd_d = ex_rd_q;  ex_rs1_d = ex_rs1_q;  ex_rs2_d = ex_rs2_q;
    ex_reg_write_d = ex_reg_write_q;  ex_mem_read_d = ex_mem_read_q;
    ex_uses_rs1_d = ex_uses_rs1_q;    ex_uses_rs2_d = ex_uses_rs2_q;
    mem_valid_d = mem_valid_q;  mem_rd_d = mem_rd_q;
    mem_reg_write_d = mem_reg_write_q;  mem_mem_read_d = mem_mem_read_q;
    wb_valid_d = wb_valid_q;  wb_rd_d = wb_rd_q;  wb_reg_write_d = wb_reg_write_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_stall) begin
      wb_valid_d      = mem_valid_q;
      wb_rd_d         = mem_rd_q;
      wb_reg_write_d  = mem_reg_write_q;
      mem_valid_d     = ex_valid_q;
      mem_rd_d        = ex_rd_q;
      mem_reg_write_d = ex_reg_write_q;
      mem_mem_read_d  = ex_mem_read_q;
      ex_valid_d      = id_valid & ~bubble_idex;
      ex_rd_d         = id_rd;
      ex_rs1_d        = id_rs1;
      ex_rs2_d        = id_rs2;
      ex_reg_write_d  = id_reg_write;
      ex_mem_read_d   = id_mem_read;
      ex_uses_rs1_d   = id_uses_rs1;
      ex_uses_rs2_d   = id_uses_rs2;
      if ((stall_if | bubble_idex) && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en_q <= 1'b0;
      ex_valid_q <= 1'b0;  ex_rd_q <= '0;  ex_rs1_q <= '0;  ex_rs2_q <= '0;
      ex_reg_write_q <= 1'b0;  ex_mem_read_q <= 1'b0;
      ex_uses_rs1_q <= 1'b0;   ex_uses_rs2_q <= 1'b0;
      mem_valid_q <= 1'b0;  mem_rd_q <= '0;  mem_reg_write_q <= 1'b0;  mem_mem_read_q <= 1'b0;
      wb_valid_q <= 1'b0;   wb_rd_q <= '0;   wb_reg_write_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_en_q <= 1'b1;
      ex_valid_q <= ex_valid_d;  ex_rd_q <= ex_rd_d;  ex_rs1_q <= ex_rs1_d;  ex_rs2_q <= ex_rs2_d;
      ex_reg_write_q <= ex_reg_write_d;  ex_mem_read_q <= ex_mem_read_d;
      ex_uses_rs1_q <= ex_uses_rs1_d;    ex_uses_rs2_q <= ex_uses_rs2_d;
      mem_valid_q <= mem_valid_d;  mem_rd_q <= mem_rd_d;
      mem_reg_write_q <= mem_reg_write_d;  mem_mem_read_q <= mem_mem_read_d;
      wb_valid_q <= wb_valid_d;  wb_rd_q <= wb_rd_d;  wb_reg_write_q <= wb_reg_write_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Backward-direction control companion to the ID/EX pipeline register.
- Shadows the destination and control of the instructions in EX, MEM and WB.
- Drives stall, bubble and flush controls back into the PC, IF/ID and ID/EX.
- Drives operand-forwarding selects to the EX-stage ALU muxes and keeps a saturating stall-cycle counter.

Parameters:
- CNT_W, 16, width of the stall/bubble performance counter.

Ports:
- clk  input  1  core clock
- rst_n  input  1  async active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs1  input  5  ID source register 1
- id_rs2  input  5  ID source register 2
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- id_rd  input  5  ID destination register
- id_reg_write  input  1  ID instruction writes rd
- id_mem_read  input  1  ID instruction is a load
- ex_branch_taken  input  1  EX resolved a taken branch/jump this cycle
- mem_stall  input  1  data memory busy; freeze whole pipeline
- stall_if  output  1  hold PC and IF/ID
- bubble_idex  output  1  load zero control into ID/EX
- flush_ifid  output  1  clear IF/ID
- freeze_all  output  1  hold every pipeline register (mirrors mem_stall)
- fwd_a_sel  output  2  EX operand A: 00 regfile, 01 MEM-stage ALU result, 10 WB data
- fwd_b_sel  output  2  EX operand B: same encoding
- stall_cnt  output  CNT_W  cycles in which stall_if or bubble_idex was asserted

Behaviour:
- Shadow registers:
  - ex_{valid,rd,reg_write,mem_read,rs1,rs2,uses_rs1,uses_rs2}
  - mem_{valid,rd,reg_write,mem_read}
  - wb_{valid,rd,reg_write}
- Reset (async, rst_n=0): all shadow state and stall_cnt cleared to 0. All outputs read 0 while reset is held and on the first cycle after release. Reset asserted mid-operation discards all in-flight tracking immediately.
- Shadow advance on posedge clk when mem_stall=0:
  - wb <= mem
  - mem <= ex
  - ex <= nop (valid=0) if bubble_idex=1, else the id_* fields with valid=id_valid.
- When mem_stall=1, all shadow state holds.
- Hazard qualifier: a source matches a stage only if the stage is valid, reg_write=1, rd!=0 and rd equals the source register. Register x0 never matches.
- Load-use: id_valid and a used ID source matches EX with ex_mem_read=1 -> load_use=1.
- Output priority (combinational, same cycle):
  1. mem_stall=1: freeze_all=1; stall_if, bubble_idex and flush_ifid are 0.
  2. ex_branch_taken=1: flush_ifid=1, bubble_idex=1, stall_if=0. The branch overrides load-use because the ID instruction is discarded.
  3. load_use=1: stall_if=1, bubble_idex=1, flush_ifid=0.
  4. Otherwise all 0.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM and the dependent instruction is still in ID, so no further load_use fires. One cycle later the dependent instruction is in EX and forwards from WB (10).
- Forwarding for EX operand A (B identical using rs2):
  - 01 if the source matches MEM and mem_mem_read=0.
  - else 10 if the source matches WB.
  - else 00.
  - MEM has priority over WB; this selects the youngest producer.
  - Selects are 00 when ex_valid=0 or the operand is unused.
- stall_cnt increments by 1 on each clk edge where stall_if|bubble_idex=1 and mem_stall=0. It saturates at all-ones and never wraps.
- No combinational path from any output back to an input.

Test Plan:
- Back-to-back ALU dependency: add x5 then sub x6,x5,x7 -> with sub in EX, fwd_a_sel=01 and stall_if=0. One instruction gap gives fwd_a_sel=10.
- Load-use: lw x3 in EX, ID uses_rs2 rs2=3 -> stall_if=1 and bubble_idex=1 for exactly 1 cycle. Two cycles later fwd_b_sel=10 and stall_cnt=1.
- x0 and unused operands: producer rd=0 or id_uses_rs1=0 with matching index -> no stall and fwd sel=00.
- Branch and load-use in the same cycle: ex_branch_taken=1 with load_use condition -> flush_ifid=1, bubble_idex=1, stall_if=0.
- mem_stall for 3 cycles mid-stream: freeze_all=1, all other controls 0, shadow state unchanged, stall_cnt unchanged. Forwarding selects after release equal those before the stall.
- Reset pulse mid-stream with a pending load-use, plus CNT_W=2 with 5 stall cycles: after reset all outputs=0 and no stall. stall_cnt saturates at 3.
